sprite_attr_fetch: RTL and testbench
====================================

Name: sprite_attr_fetch

Overview:
Read-side client of the sprite attribute RAM. On each line-start strobe it scans all sprite entries (two 32-bit words per sprite) through the RAM's read port. It decodes each entry and tests vertical visibility against the current line. Each visible sprite is handed to the sprite renderer as a decoded descriptor over a valid/ready handshake.

Parameters:
NUM_SPRITES, 128, sprite entries scanned per line (entry i occupies words 2i and 2i+1)
MAX_HITS, 128, maximum descriptors emitted per line; scan ends early when reached

Ports:
clk_i  in  1  single clock (also drives the RAM read port)
rst_n_i  in  1  asynchronous active-low reset
line_start_i  in  1  one-cycle strobe; starts (or restarts) a scan
line_i  in  10  display line sampled with line_start_i
sprite_en_i  in  1  sprites enabled, sampled with line_start_i
rd_en_o  out  1  RAM read enable
rd_addr_o  out  8  RAM read word address
rd_data_i  in  32  RAM read data, valid exactly one cycle after address
spr_valid_o  out  1  descriptor valid
spr_ready_i  in  1  renderer accepts descriptor
spr_idx_o  out  7  sprite index
spr_addr_o  out  12  word0[11:0] pattern address
spr_mode_o  out  1  word0[15], 1 = 8bpp
spr_x_o  out  10  word0[25:16]
spr_dy_o  out  6  line_i - y (row inside sprite)
spr_hflip_o  out  1  word1[16]
spr_vflip_o  out  1  word1[17]
spr_z_o  out  2  word1[19:18]
spr_coll_o  out  4  word1[23:20]
spr_pal_o  out  4  word1[27:24]
spr_width_o  out  2  word1[29:28] size code
spr_height_o  out  2  word1[31:30] size code
busy_o  out  1  scan in progress
done_o  out  1  one-cycle pulse at scan end
hit_count_o  out  8  descriptors accepted this line

Behaviour:
- Reset (async, rst_n_i low): state IDLE. All outputs are 0, and the index and hit counters are cleared.
- Size code to pixels: 0→8, 1→16, 2→32, 3→64.
- Y field is word1[9:0].
- Hit test: z != 0, and dy = (line - y) mod 1024 (10-bit wrap) satisfies dy < height_px. spr_dy_o = dy[5:0].
- States:
  - IDLE: on line_start_i, latch line_i and clear idx and hit_count. If sprite_en_i goes to RD0, else DONE.
  - RD0: rd_en_o=1, rd_addr_o={idx,0}.
  - RD1: rd_en_o=1, rd_addr_o={idx,1}; latch rd_data_i as word0.
  - EVAL: rd_data_i is word1. On hit, register all descriptor fields, set spr_valid_o=1, go OUT. On miss, go DONE if idx==NUM_SPRITES-1, else idx++ and go RD0.
  - OUT: hold spr_valid_o and all spr_* fields stable until spr_ready_i. On handshake, spr_valid_o drops the next cycle and hit_count++. Then go DONE if idx is last or hit_count reaches MAX_HITS, else idx++ and go RD0.
  - DONE: done_o=1 for one cycle, then IDLE. hit_count_o holds until the next line_start.
- Timing: a miss costs 3 cycles per sprite. A full no-hit scan is 3*NUM_SPRITES cycles from the first RD0 to DONE.
- busy_o = 1 in RD0, RD1, EVAL and OUT.
- line_start_i in any non-IDLE state aborts the scan. spr_valid_o clears, the new line is latched, and the scan restarts at idx 0 next cycle with RD0. done_o is not pulsed for the aborted scan.
- line_start_i coincident with a handshake: line_start wins. The descriptor counts as consumed by the renderer, but hit_count is reset for the new line.
- rd_en_o is 0 outside RD0 and RD1. rd_addr_o holds its last value.

Decomposition:
- Package sprite_pkg holds:
  - attribute field bit positions for word0/word1
  - size-code-to-pixel function
  - state enum
  - NUM_SPRITES default
- One combinational sub-module, sprite_attr_decode: takes word0, word1 and line; produces decoded fields, dy and hit.

Test Plan:
- Default sim RAM image (all sprites y=3, z=3, 8x8, addr 0x100, 8bpp), line_start with line=5, ready tied 1 → 128 descriptors, idx 0..127. Each has dy=2 and x=(64*idx) mod 1024. hit_count_o=128; done_o pulses once.
- Same image, line=11 → no spr_valid_o. done_o exactly 384 cycles after the first RD0 cycle; hit_count_o=0.
- Sprite 5 z set to 0, line=5 → 127 descriptors, idx 5 absent. Sprite 7 y=1020, height code 0, line=2 → sprite 7 hits with dy=6.
- spr_ready_i low for 10 cycles on the first hit → spr_valid_o and all fields stable, no RAM reads issued. Resumes correctly after ready rises.
- sprite_en_i=0 at line_start → done_o pulses next cycle, hit_count_o=0, no reads. MAX_HITS=4 → exactly 4 descriptors, then done.
- line_start during sprite 40 → valid drops, next read address 0, no done_o for the aborted scan. rst_n_i low mid-OUT → all outputs 0 immediately.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite attribute fetch path.
//   - attribute word field positions (word0 / word1)
//   - size code -> pixel conversion
//   - fetch FSM state encoding
//   - decoded descriptor struct
package sprite_pkg;

  localparam int NUM_SPRITES_DEF = 128;

  // word0 layout
  localparam int W0_ADDR_LSB = 0;   // [11:0]  pattern address
  localparam int W0_ADDR_MSB = 11;
  localparam int W0_MODE     = 15;  // 1 = 8bpp
  localparam int W0_X_LSB    = 16;  // [25:16] x position
  localparam int W0_X_MSB    = 25;

  // word1 layout
  localparam int W1_Y_LSB    = 0;   // [9:0]   y position
  localparam int W1_Y_MSB    = 9;
  localparam int W1_HFLIP    = 16;
  localparam int W1_VFLIP    = 17;
  localparam int W1_Z_LSB    = 18;  // [19:18] priority, 0 = hidden
  localparam int W1_Z_MSB    = 19;
  localparam int W1_COLL_LSB = 20;  // [23:20]
  localparam int W1_COLL_MSB = 23;
  localparam int W1_PAL_LSB  = 24;  // [27:24]
  localparam int W1_PAL_MSB  = 27;
  localparam int W1_W_LSB    = 28;  // [29:28] width size code
  localparam int W1_W_MSB    = 29;
  localparam int W1_H_LSB    = 30;  // [31:30] height size code
  localparam int W1_H_MSB    = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_EVAL,
    ST_OUT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [11:0] addr;
    logic        mode;
    logic [9:0]  x;
    logic [5:0]  dy;
    logic        hflip;
    logic        vflip;
    logic [1:0]  z;
    logic [3:0]  coll;
    logic [3:0]  pal;
    logic [1:0]  width;
    logic [1:0]  height;
  } desc_t;

  // 0->8, 1->16, 2->32, 3->64
  function automatic logic [6:0] size_px(input logic [1:0] code);
    return 7'd8 << code;
  endfunction

endpackage

// File: rtl/sprite_attr_decode.sv
// sprite_attr_decode: combinational decode of one sprite attribute entry.
//   word0, word1 : raw attribute words
//   line         : current display line
//   desc         : decoded descriptor fields (dy = row inside sprite)
//   hit          : sprite is visible on this line
module sprite_attr_decode
  import sprite_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  input  logic [9:0]  line,
  output desc_t       desc,
  output logic        hit
);

  logic [9:0] y;
  logic [9:0] dy;

  assign y  = word1[W1_Y_MSB:W1_Y_LSB];
  // 10-bit wrap lets a sprite starting near the bottom edge continue at the top
  assign dy = line - y;

  always_comb begin
    desc        = '0;
    desc.addr   = word0[W0_ADDR_MSB:W0_ADDR_LSB];
    desc.mode   = word0[W0_MODE];
    desc.x      = word0[W0_X_MSB:W0_X_LSB];
    desc.dy     = dy[5:0];
    desc.hflip  = word1[W1_HFLIP];
    desc.vflip  = word1[W1_VFLIP];
    desc.z      = word1[W1_Z_MSB:W1_Z_LSB];
    desc.coll   = word1[W1_COLL_MSB:W1_COLL_LSB];
    desc.pal    = word1[W1_PAL_MSB:W1_PAL_LSB];
    desc.width  = word1[W1_W_MSB:W1_W_LSB];
    desc.height = word1[W1_H_MSB:W1_H_LSB];
  end

  assign hit = (desc.z != 2'd0) && (dy < {3'd0, size_px(desc.height)});

  logic unused_bits;
  assign unused_bits = ^{word0[14:12], word0[31:26], word1[15:10]};

endmodule

// File: rtl/sprite_attr_fetch.sv
// sprite_attr_fetch: per-line scan of the sprite attribute RAM.
//   clk_i, rst_n_i        : clock, async active-low reset
//   line_start_i, line_i  : line strobe and line number (also aborts a scan)
//   sprite_en_i           : sprites enabled, sampled with line_start_i
//   rd_en_o, rd_addr_o    : RAM read port, rd_data_i valid one cycle later
//   spr_valid_o/ready_i   : descriptor handshake to the renderer
//   spr_*_o               : decoded descriptor of a visible sprite
//   busy_o, done_o        : scan in progress / one-cycle end pulse
//   hit_count_o           : descriptors accepted this line
module sprite_attr_fetch
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = NUM_SPRITES_DEF,
  parameter int MAX_HITS    = 128
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        line_start_i,
  input  logic [9:0]  line_i,
  input  logic        sprite_en_i,
  output logic        rd_en_o,
  output logic [7:0]  rd_addr_o,
  input  logic [31:0] rd_data_i,
  output logic        spr_valid_o,
  input  logic        spr_ready_i,
  output logic [6:0]  spr_idx_o,
  output logic [11:0] spr_addr_o,
  output logic        spr_mode_o,
  output logic [9:0]  spr_x_o,
  output logic [5:0]  spr_dy_o,
  output logic        spr_hflip_o,
  output logic        spr_vflip_o,
  output logic [1:0]  spr_z_o,
  output logic [3:0]  spr_coll_o,
  output logic [3:0]  spr_pal_o,
  output logic [1:0]  spr_width_o,
  output logic [1:0]  spr_height_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [7:0]  hit_count_o
);

  localparam logic [6:0] LAST_IDX = 7'(NUM_SPRITES - 1);
  localparam logic [7:0] HIT_LIM  = 8'(MAX_HITS);

  state_e      state;
  logic [6:0]  idx;
  logic [9:0]  line_q;
  logic [31:0] word0_q;
  desc_t       desc_q;
  desc_t       dec;
  logic        dec_hit;

  // word1 is consumed straight off the RAM port in EVAL
  sprite_attr_decode u_dec (
    .word0 (word0_q),
    .word1 (rd_data_i),
    .line  (line_q),
    .desc  (dec),
    .hit   (dec_hit)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      idx         <= '0;
      line_q      <= '0;
      word0_q     <= '0;
      desc_q      <= '0;
      spr_idx_o   <= '0;
      spr_valid_o <= 1'b0;
      rd_en_o     <= 1'b0;
      rd_addr_o   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      hit_count_o <= '0;
    end else begin
      done_o <= 1'b0;
      if (line_start_i) begin
        // new line from any state; an aborted scan ends silently
        line_q      <= line_i;
        idx         <= '0;
        hit_count_o <= '0;
        spr_valid_o <= 1'b0;
        if (sprite_en_i) begin
          state     <= ST_RD0;
          rd_en_o   <= 1'b1;
          rd_addr_o <= 8'h00;
          busy_o    <= 1'b1;
        end else begin
          state   <= ST_DONE;
          rd_en_o <= 1'b0;
          busy_o  <= 1'b0;
          done_o  <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: ;
          ST_RD0: begin
            rd_addr_o <= {idx, 1'b1};
            state     <= ST_RD1;
          end
          ST_RD1: begin
            word0_q <= rd_data_i;
            rd_en_o <= 1'b0;
            state   <= ST_EVAL;
          end
          ST_EVAL: begin
            if (dec_hit) begin
              desc_q      <= dec;
              spr_idx_o   <= idx;
              spr_valid_o <= 1'b1;
              state       <= ST_OUT;
            end else if (idx == LAST_IDX) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              idx       <= idx + 7'd1;
              rd_en_o   <= 1'b1;
              rd_addr_o <= {idx + 7'd1, 1'b0};
              state     <= ST_RD0;
            end
          end
          ST_OUT: begin
            if (spr_ready_i) begin
              spr_valid_o <= 1'b0;
              hit_count_o <= hit_count_o + 8'd1;
              if (idx == LAST_IDX || hit_count_o + 8'd1 == HIT_LIM) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
                state  <= ST_DONE;
              end else begin
                idx       <= idx + 7'd1;
                rd_en_o   <= 1'b1;
                rd_addr_o <= {idx + 7'd1, 1'b0};
                state     <= ST_RD0;
              end
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spr_addr_o   = desc_q.addr;
  assign spr_mode_o   = desc_q.mode;
  assign spr_x_o      = desc_q.x;
  assign spr_dy_o     = desc_q.dy;
  assign spr_hflip_o  = desc_q.hflip;
  assign spr_vflip_o  = desc_q.vflip;
  assign spr_z_o      = desc_q.z;
  assign spr_coll_o   = desc_q.coll;
  assign spr_pal_o    = desc_q.pal;
  assign spr_width_o  = desc_q.width;
  assign spr_height_o = desc_q.height;

endmodule

// File: tb/tb_sprite_attr_fetch.sv
module tb_sprite_attr_fetch;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        line_start_i, line_start4;
  logic [9:0]  line_i;
  logic        sprite_en_i;
  logic        spr_ready_i;

  logic        rd_en_o, rd_en4;
  logic [7:0]  rd_addr_o, rd_addr4;
  logic [31:0] rd_data_i, rd_data4;
  logic        spr_valid_o, valid4;
  logic [6:0]  spr_idx_o, idx4;
  logic [11:0] spr_addr_o, addr4;
  logic        spr_mode_o, mode4;
  logic [9:0]  spr_x_o, x4;
  logic [5:0]  spr_dy_o, dy4;
  logic        spr_hflip_o, hflip4, spr_vflip_o, vflip4;
  logic [1:0]  spr_z_o, z4;
  logic [3:0]  spr_coll_o, coll4, spr_pal_o, pal4;
  logic [1:0]  spr_width_o, width4, spr_height_o, height4;
  logic        busy_o, busy4, done_o, done4;
  logic [7:0]  hit_count_o, hit_count4;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0, rd_cnt = 0, hs4 = 0, done4_cnt = 0;
  int first_rd0 = -1, done_cyc = -1;
  logic [51:0] q [$];

  always #5 clk_i = ~clk_i;

  sprite_attr_fetch dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .line_start_i(line_start_i), .line_i(line_i),
    .sprite_en_i(sprite_en_i), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .spr_valid_o(spr_valid_o), .spr_ready_i(spr_ready_i), .spr_idx_o(spr_idx_o),
    .spr_addr_o(spr_addr_o), .spr_mode_o(spr_mode_o), .spr_x_o(spr_x_o), .spr_dy_o(spr_dy_o),
    .spr_hflip_o(spr_hflip_o), .spr_vflip_o(spr_vflip_o), .spr_z_o(spr_z_o),
    .spr_coll_o(spr_coll_o), .spr_pal_o(spr_pal_o), .spr_width_o(spr_width_o),
    .spr_height_o(spr_height_o), .busy_o(busy_o), .done_o(done_o), .hit_count_o(hit_count_o)
  );

  sprite_attr_fetch #(.NUM_SPRITES(128), .MAX_HITS(4)) dut4 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .line_start_i(line_start4), .line_i(line_i),
    .sprite_en_i(sprite_en_i), .rd_en_o(rd_en4), .rd_addr_o(rd_addr4), .rd_data_i(rd_data4),
    .spr_valid_o(valid4), .spr_ready_i(spr_ready_i), .spr_idx_o(idx4),
    .spr_addr_o(addr4), .spr_mode_o(mode4), .spr_x_o(x4), .spr_dy_o(dy4),
    .spr_hflip_o(hflip4), .spr_vflip_o(vflip4), .spr_z_o(z4),
    .spr_coll_o(coll4), .spr_pal_o(pal4), .spr_width_o(width4),
    .spr_height_o(height4), .busy_o(busy4), .done_o(done4), .hit_count_o(hit_count4)
  );

  // synchronous-read RAM models, one read port per DUT
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rd_en_o) rd_data_i <= mem[rd_addr_o];
    if (rd_en4)  rd_data4  <= mem[rd_addr4];
  end

  wire [51:0] cur = {spr_idx_o, spr_addr_o, spr_mode_o, spr_x_o, spr_dy_o, spr_hflip_o,
                     spr_vflip_o, spr_z_o, spr_coll_o, spr_pal_o, spr_width_o, spr_height_o};

  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (spr_valid_o && spr_ready_i) q.push_back(cur);
      if (done_o) begin done_cnt++; done_cyc = cyc; end
      if (rd_en_o) rd_cnt++;
      if (rd_en_o && rd_addr_o == 8'h00 && first_rd0 < 0) first_rd0 = cyc;
      if (valid4 && spr_ready_i) hs4++;
      if (done4) done4_cnt++;
    end
  end

  // default image: y=3, z=3, 8x8, addr 0x100, 8bpp, x=64*i; flips/coll/pal vary with i
  task automatic load_image();
    for (int i = 0; i < 128; i++) begin
      mem[2*i]   = {6'd0, 10'(64*i), 1'b1, 3'd0, 12'h100};
      mem[2*i+1] = {2'd0, 2'd0, 4'(i), 4'(i >> 2), 2'd3, 1'(i >> 1), 1'(i), 6'd0, 10'd3};
    end
  endtask

  function automatic logic [51:0] model_desc(input int i, input logic [5:0] dy);
    logic [6:0] ix;
    ix = 7'(i);
    return {ix, 12'h100, 1'b1, 10'(64*i), dy, ix[0], ix[1], 2'd3, ix[5:2], ix[3:0], 2'd0, 2'd0};
  endfunction

  task automatic start_line(input logic [9:0] ln, input logic en);
    @(posedge clk_i); #1;
    line_i = ln; sprite_en_i = en; line_start_i = 1'b1;
    @(posedge clk_i); #1;
    line_start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n0;
    n0 = done_cnt;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk_i);
      if (done_cnt != n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_i);
      if (spr_valid_o) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if ({spr_valid_o, busy_o, done_o, rd_en_o, rd_addr_o, hit_count_o, cur} !== '0) begin
      errors++; $display("FAIL reset_outputs: got valid=%b busy=%b rd_en=%b addr=%h desc=%h, want all 0",
                         spr_valid_o, busy_o, rd_en_o, rd_addr_o, cur);
    end
    @(posedge clk_i); #1 rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({spr_valid_o, busy_o, done_o, rd_en_o, hit_count_o} !== '0) begin
      errors++; $display("FAIL idle_after_reset: valid=%b busy=%b done=%b rd_en=%b hits=%0d, want 0",
                         spr_valid_o, busy_o, done_o, rd_en_o, hit_count_o);
    end
  endtask

  task automatic test_all_hit();
    bit ok;
    load_image(); spr_ready_i = 1'b1; q.delete(); done_cnt = 0;
    start_line(10'd5, 1'b1);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL all_hit_done_timeout: no done_o, want one"); end
    repeat (5) @(posedge clk_i);
    checks++;
    if (q.size() != 128) begin errors++; $display("FAIL all_hit_count: got %0d descriptors, want 128", q.size()); end
    for (int k = 0; k < q.size() && k < 128; k++) begin
      checks++;
      if (q[k] !== model_desc(k, 6'd2)) begin
        errors++; $display("FAIL all_hit_desc[%0d]: got %h, want %h", k, q[k], model_desc(k, 6'd2));
      end
    end
    checks++; if (hit_count_o !== 8'd128) begin errors++; $display("FAIL all_hit_hitcount: got %0d, want 128", hit_count_o); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL all_hit_done_pulses: got %0d, want 1", done_cnt); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL all_hit_busy: got %b, want 0", busy_o); end
  endtask

  task automatic test_no_hit();
    bit ok;
    load_image(); spr_ready_i = 1'b1; q.delete(); done_cnt = 0; first_rd0 = -1; done_cyc = -1;
    start_line(10'd11, 1'b1);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL no_hit_done_timeout: no done_o, want one"); end
    repeat (3) @(posedge clk_i);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL no_hit_count: got %0d descriptors, want 0", q.size()); end
    checks++;
    if (done_cyc - first_rd0 != 384) begin
      errors++; $display("FAIL no_hit_latency: got %0d cycles RD0->done, want 384", done_cyc - first_rd0);
    end
    checks++; if (hit_count_o !== 8'd0) begin errors++; $display("FAIL no_hit_hitcount: got %0d, want 0", hit_count_o); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL no_hit_done_pulses: got %0d, want 1", done_cnt); end
  endtask

  task automatic test_z_zero();
    bit ok;
    load_image(); mem[11][19:18] = 2'd0;
    spr_ready_i = 1'b1; q.delete(); done_cnt = 0;
    start_line(10'd5, 1'b1);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL z0_done_timeout: no done_o, want one"); end
    repeat (3) @(posedge clk_i);
    checks++; if (q.size() != 127) begin errors++; $display("FAIL z0_count: got %0d descriptors, want 127", q.size()); end
    for (int k = 0; k < q.size() && k < 127; k++) begin
      checks++;
      if (q[k] !== model_desc(k < 5 ? k : k + 1, 6'd2)) begin
        errors++; $display("FAIL z0_desc[%0d]: got %h, want %h", k, q[k], model_desc(k < 5 ? k : k + 1, 6'd2));
      end
    end
    checks++; if (hit_count_o !== 8'd127) begin errors++; $display("FAIL z0_hitcount: got %0d, want 127", hit_count_o); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [51:0] exp;
    load_image();
    mem[15] = {2'd0, 2'd0, 4'd7, 4'd1, 2'd3, 1'b1, 1'b1, 6'd0, 10'd1020};
    exp = {7'd7, 12'h100, 1'b1, 10'd448, 6'd6, 1'b1, 1'b1, 2'd3, 4'd1, 4'd7, 2'd0, 2'd0};
    spr_ready_i = 1'b1; q.delete(); done_cnt = 0;
    start_line(10'd2, 1'b1);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done_timeout: no done_o, want one"); end
    repeat (3) @(posedge clk_i);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL wrap_count: got %0d descriptors, want 1", q.size()); end
    checks++;
    if (q.size() > 0 && q[0] !== exp) begin errors++; $display("FAIL wrap_desc: got %h, want %h", q[0], exp); end
    checks++; if (hit_count_o !== 8'd1) begin errors++; $display("FAIL wrap_hitcount: got %0d, want 1", hit_count_o); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [51:0] snap;
    int rd0;
    load_image(); spr_ready_i = 1'b0; q.delete(); done_cnt = 0;
    start_line(10'd5, 1'b1);
    wait_valid(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_valid_timeout: spr_valid_o never rose"); end
    snap = cur; rd0 = rd_cnt;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      checks++;
      if (!spr_valid_o || cur !== snap) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%b desc=%h, want valid=1 desc=%h", k, spr_valid_o, cur, snap);
      end
    end
    checks++; if (rd_cnt != rd0) begin errors++; $display("FAIL bp_no_reads: got %0d reads while stalled, want 0", rd_cnt - rd0); end
    checks++; if (snap !== model_desc(0, 6'd2)) begin errors++; $display("FAIL bp_first_desc: got %h, want %h", snap, model_desc(0, 6'd2)); end
    @(posedge clk_i); #1 spr_ready_i = 1'b1;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done_timeout: no done_o, want one"); end
    repeat (3) @(posedge clk_i);
    checks++; if (q.size() != 128) begin errors++; $display("FAIL bp_count: got %0d descriptors, want 128", q.size()); end
    checks++;
    if (q.size() == 128 && q[127] !== model_desc(127, 6'd2)) begin
      errors++; $display("FAIL bp_last_desc: got %h, want %h", q[127], model_desc(127, 6'd2));
    end
    checks++; if (hit_count_o !== 8'd128) begin errors++; $display("FAIL bp_hitcount: got %0d, want 128", hit_count_o); end
  endtask

  task automatic test_disabled();
    done_cnt = 0; rd_cnt = 0;
    start_line(10'd5, 1'b0);
    @(negedge clk_i);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL dis_done_next: got %b, want 1", done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL dis_busy: got %b, want 0", busy_o); end
    repeat (5) @(posedge clk_i);
    checks++; if (rd_cnt != 0) begin errors++; $display("FAIL dis_reads: got %0d reads, want 0", rd_cnt); end
    checks++; if (hit_count_o !== 8'd0) begin errors++; $display("FAIL dis_hitcount: got %0d, want 0", hit_count_o); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL dis_done_pulses: got %0d, want 1", done_cnt); end
    sprite_en_i = 1'b1;
  endtask

  task automatic test_max_hits();
    bit ok;
    load_image(); spr_ready_i = 1'b1; hs4 = 0; done4_cnt = 0;
    @(posedge clk_i); #1 line_i = 10'd5; sprite_en_i = 1'b1; line_start4 = 1'b1;
    @(posedge clk_i); #1 line_start4 = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk_i);
      if (done4_cnt != 0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL max_done_timeout: no done_o, want one"); end
    repeat (10) @(posedge clk_i);
    checks++; if (hs4 != 4) begin errors++; $display("FAIL max_count: got %0d descriptors, want 4", hs4); end
    checks++; if (hit_count4 !== 8'd4) begin errors++; $display("FAIL max_hitcount: got %0d, want 4", hit_count4); end
    checks++; if (done4_cnt != 1 || busy4 !== 1'b0) begin
      errors++; $display("FAIL max_end: done pulses=%0d busy=%b, want 1 and 0", done4_cnt, busy4);
    end
  endtask

  task automatic test_abort();
    bit ok;
    load_image(); spr_ready_i = 1'b1; q.delete(); done_cnt = 0;
    start_line(10'd5, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_i);
      if (spr_valid_o && spr_idx_o == 7'd40) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL abort_reach40_timeout: sprite 40 never offered"); end
    // line_start coincides with the sprite-40 handshake
    line_i = 10'd5; line_start_i = 1'b1;
    @(posedge clk_i); #1 line_start_i = 1'b0;
    q.delete(); done_cnt = 0;
    @(negedge clk_i);
    checks++;
    if (spr_valid_o !== 1'b0 || rd_en_o !== 1'b1 || rd_addr_o !== 8'h00) begin
      errors++; $display("FAIL abort_restart: valid=%b rd_en=%b addr=%h, want 0 1 00", spr_valid_o, rd_en_o, rd_addr_o);
    end
    checks++; if (hit_count_o !== 8'd0) begin errors++; $display("FAIL abort_hitcount_clr: got %0d, want 0", hit_count_o); end
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_done_timeout: no done_o, want one"); end
    repeat (3) @(posedge clk_i);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_done_pulses: got %0d, want 1", done_cnt); end
    checks++; if (q.size() != 128) begin errors++; $display("FAIL abort_count: got %0d descriptors, want 128", q.size()); end
    checks++; if (hit_count_o !== 8'd128) begin errors++; $display("FAIL abort_hitcount: got %0d, want 128", hit_count_o); end
  endtask

  task automatic test_reset_mid_out();
    bit ok;
    load_image(); spr_ready_i = 1'b0;
    start_line(10'd5, 1'b1);
    wait_valid(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_valid_timeout: spr_valid_o never rose"); end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({spr_valid_o, busy_o, done_o, rd_en_o, rd_addr_o, hit_count_o, cur} !== '0) begin
      errors++; $display("FAIL rst_mid_out: valid=%b busy=%b rd_en=%b addr=%h desc=%h, want all 0",
                         spr_valid_o, busy_o, rd_en_o, rd_addr_o, cur);
    end
    @(posedge clk_i); #1 rst_n_i = 1'b1; spr_ready_i = 1'b1;
  endtask

  initial begin
    rst_n_i = 1'b0; line_start_i = 1'b0; line_start4 = 1'b0;
    line_i = '0; sprite_en_i = 1'b1; spr_ready_i = 1'b1;
    load_image();
    repeat (3) @(posedge clk_i);
    test_reset();
    test_all_hit();
    test_no_hit();
    test_z_zero();
    test_wrap();
    test_backpressure();
    test_disabled();
    test_max_hits();
    test_abort();
    test_reset_mid_out();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
